// File: rtl/sbox_share_sched.sv
// sbox_share_sched
//
// Shares one byte-wide AES S-box between the round datapath (SubBytes,
// 16-byte state jobs) and the key schedule (SubWord, 4-byte key jobs).
// A job is accepted whole. Its bytes go into the S-box one per cycle,
// ascending from byte 0. The returned bytes are collected by index, and
// the finished word is shown with a one-cycle valid pulse.
//
// Handshake: a job moves across st_* or ky_* on a clock edge where both
// valid and ready are 1. Ready is only raised in IDLE, and only for the
// requester picked by the arbiter. The input data is sampled on that
// edge. Completion outputs have no ready; they cannot be stalled.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   st_valid/ready    state job request / accept
//   st_data           128-bit state, byte i = st_data[8i+7:8i]
//   st_out_valid      one-cycle pulse, st_out_data complete
//   st_out_data       substituted state (held until the next state job)
//   ky_valid/ready    key job request / accept
//   ky_data           32-bit word, byte i = ky_data[8i+7:8i]
//   ky_out_valid      one-cycle pulse, ky_out_data complete
//   ky_out_data       substituted word (held until the next key job)
//   sb_issue, sb_in   byte offered to the shared S-box this cycle
//   sb_out            S-box result, SBOX_LAT cycles after its sb_issue
//   busy              FSM is not in IDLE
module sbox_share_sched #(
    parameter int SBOX_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    input  logic [127:0] st_data,
    output logic         st_ready,
    output logic         st_out_valid,
    output logic [127:0] st_out_data,
    input  logic         ky_valid,
    input  logic [31:0]  ky_data,
    output logic         ky_ready,
    output logic         ky_out_valid,
    output logic [31:0]  ky_out_data,
    output logic         sb_issue,
    output logic [7:0]   sb_in,
    input  logic [7:0]   sb_out,
    output logic         busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]   state;
    logic         job_ky;       // 1: current job is a key job
    logic         last_ky;      // last grant went to the key requester
    logic [127:0] job_data;
    logic [127:0] result;
    logic [127:0] result_next;
    logic [3:0]   k;            // index of the byte being issued
    logic [3:0]   last_idx;

    // Delay line carrying the issue strobe and byte index alongside the
    // S-box. Stage SBOX_LAT-1 lines up with the matching sb_out.
    logic [SBOX_LAT-1:0] pipe_v;
    logic [3:0]          pipe_idx [SBOX_LAT];

    logic       cap;
    logic [3:0] cap_idx;
    logic       sel_ky;

    assign last_idx = job_ky ? 4'd3 : 4'd15;

    // On a tie the requester that was not served last wins. last_ky resets
    // to 0 (state), so the key requester wins the first tie after reset.
    assign sel_ky   = ky_valid && (!st_valid || !last_ky);
    assign st_ready = (state == IDLE) && st_valid && !sel_ky;
    assign ky_ready = (state == IDLE) && sel_ky;

    assign sb_issue = (state == ISSUE);
    assign sb_in    = sb_issue ? job_data[{k, 3'b000} +: 8] : 8'h00;
    assign busy     = (state != IDLE);

    assign st_out_valid = (state == DONE) && !job_ky;
    assign ky_out_valid = (state == DONE) && job_ky;

    assign cap     = pipe_v[SBOX_LAT-1] && ((state == ISSUE) || (state == DRAIN));
    assign cap_idx = pipe_idx[SBOX_LAT-1];

    // The returned byte is merged here so that the edge entering DONE can
    // publish a result that already contains the final byte.
    always_comb begin
        result_next = result;
        if (cap) begin
            result_next[{cap_idx, 3'b000} +: 8] = sb_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= 4'd0;
            job_ky      <= 1'b0;
            last_ky     <= 1'b0;
            job_data    <= '0;
            result      <= '0;
            st_out_data <= '0;
            ky_out_data <= '0;
            pipe_v      <= '0;
            for (int i = 0; i < SBOX_LAT; i++) begin
                pipe_idx[i] <= 4'd0;
            end
        end else begin
            pipe_v[0]   <= sb_issue;
            pipe_idx[0] <= k;
            for (int i = 1; i < SBOX_LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            result <= result_next;

            case (state)
                IDLE: begin
                    if (st_ready || ky_ready) begin
                        job_ky   <= ky_ready;
                        last_ky  <= ky_ready;
                        job_data <= ky_ready ? {96'd0, ky_data} : st_data;
                        result   <= '0;
                        k        <= 4'd0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    k <= k + 4'd1;
                    if (k == last_idx) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cap && (cap_idx == last_idx)) begin
                        state <= DONE;
                        if (job_ky) begin
                            ky_out_data <= result_next[31:0];
                        end else begin
                            st_out_data <= result_next;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_share_sched.sv
// Testbench for sbox_share_sched. The bench models the shared S-box itself:
// it computes the GF(2^8) inverse followed by the affine map, and adds a
// fixed latency. It also keeps a job-level reference of arbitration order,
// timing and results.
module tb_sbox_share_sched;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         st_valid = 1'b0;
    logic [127:0] st_data = '0;
    logic         st_ready;
    logic         st_out_valid;
    logic [127:0] st_out_data;
    logic         ky_valid = 1'b0;
    logic [31:0]  ky_data = '0;
    logic         ky_ready;
    logic         ky_out_valid;
    logic [31:0]  ky_out_data;
    logic         sb_issue;
    logic [7:0]   sb_in;
    logic [7:0]   sb_out;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit m_last_ky = 1'b0;

    sbox_share_sched #(.SBOX_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready),
        .st_out_valid(st_out_valid), .st_out_data(st_out_data),
        .ky_valid(ky_valid), .ky_data(ky_data), .ky_ready(ky_ready),
        .ky_out_valid(ky_out_valid), .ky_out_data(ky_out_data),
        .sb_issue(sb_issue), .sb_in(sb_in), .sb_out(sb_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_out(input bit is_ky, input logic [127:0] d);
        logic [127:0] r = '0;
        int n = is_ky ? 4 : 16;
        for (int i = 0; i < n; i++) r[8*i +: 8] = sbox_f(d[8*i +: 8]);
        return r;
    endfunction

    // External S-box model: fixed latency, and junk on cycles with no valid result
    logic [LAT-1:0] sbm_v = '0;
    logic [7:0]     sbm [LAT];
    logic [7:0]     junk = 8'h00;
    always @(posedge clk) begin
        sbm_v[0] <= sb_issue;
        sbm[0]   <= sb_in;
        for (int i = 1; i < LAT; i++) begin
            sbm_v[i] <= sbm_v[i-1];
            sbm[i]   <= sbm[i-1];
        end
        junk <= 8'($urandom);
    end
    assign sb_out = sbm_v[LAT-1] ? sbox_f(sbm[LAT-1]) : junk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic jitter();
        st_data = rand128();
        ky_data = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        st_valid = 1'b0;
        ky_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {st_ready, ky_ready, st_out_valid, ky_out_valid, sb_issue, busy, sb_in},
            '0);
        chk("reset_data", {ky_out_data, st_out_data}, '0);
        rst = 1'b0;
        m_last_ky = 1'b0;
    endtask

    // Runs `jobs` accepted jobs with the chosen requesters held valid, then drops valid.
    task automatic stream(input bit want_st, input bit want_ky, input int jobs,
                          input logic [127:0] st_d0, input logic [31:0] ky_d0);
        int prev_acc = -1;
        int prev_n = 0;
        st_valid = want_st;
        ky_valid = want_ky;
        st_data = st_d0;
        ky_data = ky_d0;
        #1;
        for (int j = 0; j < jobs; j++) begin
            bit exp_ky, g_ky, ov;
            int guard = 0;
            int n, acc;
            logic [127:0] d, hold;
            exp_ky = want_ky && (!want_st || !m_last_ky);
            while (!st_ready && !ky_ready && guard < 60) begin
                jitter();
                @(negedge clk);
                guard++;
            end
            chk("ready_timeout", 128'(guard < 60), 128'(1));
            chk("both_ready", 128'(st_ready && ky_ready), 128'(0));
            chk("grant", 128'(ky_ready), 128'(exp_ky));
            if (prev_acc >= 0) chk("accept_gap", 128'(cyc - prev_acc), 128'(prev_n + LAT + 2));
            g_ky = ky_ready;
            d = g_ky ? {96'd0, ky_data} : st_data;
            n = g_ky ? 4 : 16;
            acc = cyc;
            m_last_ky = g_ky;
            hold = g_ky ? st_out_data : {96'd0, ky_out_data};
            @(negedge clk);
            if (j == jobs - 1) begin
                st_valid = 1'b0;
                ky_valid = 1'b0;
            end
            for (int k = 0; k < n; k++) begin
                chk("ready_in_job", {st_ready, ky_ready}, '0);
                chk("issue", {sb_issue, busy, sb_in}, {1'b1, 1'b1, d[8*k +: 8]});
                jitter();
                @(negedge clk);
            end
            guard = 0;
            ov = g_ky ? ky_out_valid : st_out_valid;
            while (!ov && guard < 10) begin
                chk("drain_no_issue", 128'(sb_issue), 128'(0));
                jitter();
                @(negedge clk);
                guard++;
                ov = g_ky ? ky_out_valid : st_out_valid;
            end
            chk("done_cycle", 128'(cyc - acc), 128'(n + LAT + 1));
            if (g_ky) begin
                chk("ky_result", {96'd0, ky_out_data}, model_out(1'b1, d));
                chk("st_untouched", {st_out_valid, st_out_data}, {1'b0, hold});
            end else begin
                chk("st_result", st_out_data, model_out(1'b0, d));
                chk("ky_untouched", {ky_out_valid, ky_out_data}, {1'b0, hold[31:0]});
            end
            jitter();
            @(negedge clk);
            chk("pulse_end", {st_out_valid, ky_out_valid, busy}, '0);
            prev_acc = acc;
            prev_n = n;
        end
    endtask

    initial begin
        logic [127:0] d0;
        @(negedge clk);
        do_reset();

        // Single key job, ready in the first cycle
        ky_valid = 1'b1;
        ky_data = 32'hcf4f3c09;
        #1;
        chk("ky_ready_first", 128'(ky_ready), 128'(1));
        stream(1'b0, 1'b1, 1, '0, 32'hcf4f3c09);
        chk("ky_known", 128'(ky_out_data), 128'(32'h8a84eb01));

        // All-zero state job
        stream(1'b1, 1'b0, 1, '0, '0);
        chk("st_zero", st_out_data, {16{8'h63}});
        chk("ky_kept", 128'(ky_out_data), 128'(32'h8a84eb01));

        // Non-trivial low bytes
        d0 = '0;
        d0[15:0] = 16'h0153;
        stream(1'b1, 1'b0, 1, d0, '0);
        chk("st_known", st_out_data, {{14{8'h63}}, 8'h7c, 8'hed});

        // Both requesting continuously from reset: key, state, key, state ...
        do_reset();
        stream(1'b1, 1'b1, 4, rand128(), $urandom);

        // Back-to-back key jobs with valid held high
        stream(1'b0, 1'b1, 2, '0, $urandom);

        // Random mixes
        for (int r = 0; r < 6; r++) begin
            int sel = $urandom_range(1, 3);
            stream(sel[0], sel[1], $urandom_range(1, 3), rand128(), $urandom);
        end

        // Reset in the 8th issue cycle of a state job
        st_valid = 1'b1;
        st_data = rand128();
        #1;
        begin
            int guard = 0;
            while (!st_ready && guard < 60) begin
                @(negedge clk);
                guard++;
            end
            chk("mid_ready", 128'(st_ready), 128'(1));
        end
        @(negedge clk);
        st_valid = 1'b0;
        for (int k = 0; k < 7; k++) @(negedge clk);
        chk("mid_issue8", {sb_issue, sb_in}, {1'b1, st_data[63:56]});
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs",
            {st_ready, ky_ready, st_out_valid, ky_out_valid, sb_issue, busy, sb_in},
            '0);
        chk("mid_reset_data", {ky_out_data, st_out_data}, '0);
        rst = 1'b0;
        m_last_ky = 1'b0;
        stream(1'b0, 1'b1, 1, '0, 32'h00000001);
        chk("post_reset_ky", 128'(ky_out_data), 128'(32'h6363637c));
        chk("post_reset_st", st_out_data, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
- Schedules one shared byte-wide AES S-box (GF inverse + affine stage) between two requesters:
  - the round datapath's SubBytes, which needs 16 bytes;
  - the key-expansion SubWord, which needs 4 bytes.
- Accepts whole jobs, serialises the bytes into the S-box at one byte per cycle, and reassembles the returned bytes.
- Presents one completed word per job.
- Sits between the round controller / key scheduler and the single S-box instance, which saves 19 S-box copies.

Parameters:
- SBOX_LAT, 1: fixed S-box latency in cycles from sb_issue to the matching sb_out. Legal range 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- st_valid  in  1  state job request
- st_data  in  128  state; byte i = st_data[8i+7:8i]
- st_ready  out  1  state job accepted when st_valid&st_ready
- st_out_valid  out  1  one-cycle pulse: st_out_data complete
- st_out_data  out  128  substituted state, same byte order
- ky_valid  in  1  key job request
- ky_data  in  32  word; byte i = ky_data[8i+7:8i]
- ky_ready  out  1  key job accepted when ky_valid&ky_ready
- ky_out_valid  out  1  one-cycle pulse: ky_out_data complete
- ky_out_data  out  32  substituted word
- sb_issue  out  1  byte presented to S-box this cycle
- sb_in  out  8  byte to S-box
- sb_out  in  8  S-box result, valid SBOX_LAT cycles after the matching sb_issue
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0; FSM goes to IDLE; byte counter 0; issue delay line cleared; last_grant=ST. On reset, an in-flight job is discarded and late sb_out values are ignored.
- FSM states are IDLE, ISSUE, DRAIN, DONE.
- IDLE, arbitration:
  - Only one requester valid: that requester is selected.
  - Both valid: the requester that is not last_grant is selected, so key wins the first tie after reset.
  - st_ready = IDLE & st_valid selected; ky_ready = IDLE & ky_valid selected. Both readys are never 1 together.
- Acceptance:
  - On handshake, register the job data, the job type and N (16 for ST, 4 for KY).
  - last_grant := job type; go to ISSUE.
- ISSUE:
  - Byte k is driven each cycle, k=0..N-1 ascending: sb_issue=1, sb_in=byte k.
  - After k=N-1, go to DRAIN.
  - sb_issue=0 in every other state, and sb_in=0 then.
- Capture:
  - A SBOX_LAT-deep shift register carries the issue strobe and byte index.
  - When its output strobe is 1, sb_out is written into result byte[index].
  - Capture runs in ISSUE and DRAIN.
- DRAIN: stay until the last byte has been captured, then go to DONE.
- DONE:
  - Assert the job's out_valid for exactly one cycle.
  - out_data is updated to the result on that same cycle and holds until that requester's next completion.
  - Go to IDLE.
  - There is no output backpressure.
- Latency, for acceptance edge at cycle t:
  - Issues occur in cycles t+1..t+N.
  - out_valid is high in cycle t+N+SBOX_LAT+1.
  - Earliest next acceptance is cycle t+N+SBOX_LAT+2.
- Requests are not preempted: a job runs to completion while the other requester waits.
- Input data changes while not handshaking are ignored.
- Asserting valid with data that changes before ready is legal; the value at the handshake edge is used.
- The other output channel is never disturbed by a job; its out_data is unchanged.

Test Plan:
- Reset, then ky_valid=1, ky_data=32'hcf4f3c09 (SBOX_LAT=1) -> ky_ready in the first cycle; sb_in sequence 09,3c,4f,cf; ky_out_valid pulse 6 cycles after acceptance; ky_out_data=32'h8a84eb01.
- st_valid with st_data=128'h0 -> 16 issues of 00; st_out_data=128'h6363…63 (all bytes 63); st_out_valid pulse 18 cycles after acceptance; ky_out_data unchanged.
- st_valid and ky_valid asserted together, continuously, from reset:
  - key served first, then state, then key;
  - grants alternate;
  - no cycle has both readys high;
  - each out_valid pulse matches its data.
- SBOX_LAT=3 build, st byte0=53, byte1=01, others 00 -> result byte0=ED, byte1=7C, rest 63; out_valid 20 cycles after acceptance.
- rst pulsed in the 8th ISSUE cycle of a state job -> next cycle all outputs 0 and IDLE; a following key job 32'h00000001 -> 32'h6363637c, no corruption from stale sb_out.
- Back-to-back key jobs with valid held high -> second acceptance exactly SBOX_LAT+6 cycles after the first.
